// File: rtl/dafx_cfg_axi4l_master.sv
// Single-outstanding AXI4-Lite initiator for the DAFX configuration register file.
// Optional bus watchdog: define DAFX_CFG_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module dafx_cfg_axi4l_master #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] HIGH_ADDRESS   = 'h0034
`ifdef DAFX_CFG_TIMEOUT_EN
  ,
  parameter int                        TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_local_err,
  output logic                        rsp_timeout,
  output logic                        busy,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]                  awprot,
  output logic                        wvalid,
  input  logic                        wready,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        bvalid,
  output logic                        bready,
  input  logic [1:0]                  bresp,
  output logic                        arvalid,
  input  logic                        arready,
  output logic [AXI_ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]                  arprot,
  input  logic                        rvalid,
  output logic                        rready,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                  rresp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RESPOND = 3'd5
  } state_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                      state_reg;
  logic                        cmd_ready_reg;
  logic                        busy_reg;
  logic                        rsp_valid_reg;
  logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [1:0]                  rsp_resp_reg;
  logic                        rsp_local_err_reg;
  logic                        awvalid_reg;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_reg;
  logic                        wvalid_reg;
  logic [AXI_DATA_WIDTH-1:0]   wdata_reg;
  logic                        bready_reg;
  logic                        arvalid_reg;
  logic [AXI_ADDR_WIDTH-1:0]   araddr_reg;
  logic                        rready_reg;

  logic addr_bad;
  logic wr_req_done;

  // Reject out-of-window or unaligned addresses before touching the bus.
  assign addr_bad    = (cmd_addr >= HIGH_ADDRESS) || (cmd_addr[1:0] != 2'b00);
  // AW and W retire independently; the request phase ends once neither is still pending.
  assign wr_req_done = (!awvalid_reg || awready) && (!wvalid_reg || wready);

`ifdef DAFX_CFG_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic             rsp_timeout_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             in_bus;
  logic             wd_fire;

  assign in_bus  = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                   (state_reg == RD_REQ) || (state_reg == RD_RESP);
  assign wd_fire = in_bus && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_reg;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      cmd_ready_reg     <= 1'b0;
      busy_reg          <= 1'b0;
      rsp_valid_reg     <= 1'b0;
      rsp_rdata_reg     <= '0;
      rsp_resp_reg      <= 2'b00;
      rsp_local_err_reg <= 1'b0;
      awvalid_reg       <= 1'b0;
      awaddr_reg        <= '0;
      wvalid_reg        <= 1'b0;
      wdata_reg         <= '0;
      bready_reg        <= 1'b0;
      arvalid_reg       <= 1'b0;
      araddr_reg        <= '0;
      rready_reg        <= 1'b0;
`ifdef DAFX_CFG_TIMEOUT_EN
      rsp_timeout_reg   <= 1'b0;
      timer_reg         <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (addr_bad) begin
              state_reg         <= RESPOND;
              rsp_valid_reg     <= 1'b1;
              rsp_resp_reg      <= RESP_SLVERR;
              rsp_local_err_reg <= 1'b1;
              rsp_rdata_reg     <= '0;
            end else if (cmd_write) begin
              state_reg   <= WR_REQ;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              awaddr_reg  <= cmd_addr;
              wdata_reg   <= cmd_wdata;
            end else begin
              state_reg   <= RD_REQ;
              arvalid_reg <= 1'b1;
              araddr_reg  <= cmd_addr;
            end
          end
        end

        WR_REQ: begin
          if (awready) awvalid_reg <= 1'b0;
          if (wready)  wvalid_reg  <= 1'b0;
          if (wr_req_done) begin
            state_reg  <= WR_RESP;
            bready_reg <= 1'b1;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            state_reg     <= RESPOND;
            bready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_resp_reg  <= bresp;
            rsp_rdata_reg <= '0;
          end
        end

        RD_REQ: begin
          if (arready) begin
            state_reg   <= RD_RESP;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
          end
        end

        RD_RESP: begin
          if (rvalid) begin
            state_reg     <= RESPOND;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_resp_reg  <= rresp;
            rsp_rdata_reg <= rdata;
          end
        end

        RESPOND: begin
          // Returning straight to IDLE with cmd_ready set gives the one-cycle command gap.
          if (rsp_ready) begin
            state_reg         <= IDLE;
            rsp_valid_reg     <= 1'b0;
            rsp_rdata_reg     <= '0;
            rsp_resp_reg      <= 2'b00;
            rsp_local_err_reg <= 1'b0;
            busy_reg          <= 1'b0;
            cmd_ready_reg     <= 1'b1;
`ifdef DAFX_CFG_TIMEOUT_EN
            rsp_timeout_reg   <= 1'b0;
`endif
          end
        end

        default: state_reg <= IDLE;
      endcase

`ifdef DAFX_CFG_TIMEOUT_EN
      if (in_bus) timer_reg <= timer_reg + 1'b1;
      else        timer_reg <= '0;

      // Watchdog abort overrides whatever the bus states scheduled this cycle.
      if (wd_fire) begin
        state_reg         <= RESPOND;
        awvalid_reg       <= 1'b0;
        wvalid_reg        <= 1'b0;
        bready_reg        <= 1'b0;
        arvalid_reg       <= 1'b0;
        rready_reg        <= 1'b0;
        rsp_valid_reg     <= 1'b1;
        rsp_resp_reg      <= RESP_SLVERR;
        rsp_rdata_reg     <= '0;
        rsp_local_err_reg <= 1'b0;
        rsp_timeout_reg   <= 1'b1;
      end
`endif
    end
  end

  assign cmd_ready     = cmd_ready_reg;
  assign busy          = busy_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;
  assign rsp_local_err = rsp_local_err_reg;
  assign awvalid       = awvalid_reg;
  assign awaddr        = awaddr_reg;
  assign awprot        = 3'b000;
  assign wvalid        = wvalid_reg;
  assign wdata         = wdata_reg;
  assign wstrb         = '1;
  assign bready        = bready_reg;
  assign arvalid       = arvalid_reg;
  assign araddr        = araddr_reg;
  assign arprot        = 3'b000;
  assign rready        = rready_reg;

endmodule
